// File: rtl/rob_commit_unit_pkg.sv
// Shared ROB sizing constants and record types for the commit path.
package rob_commit_unit_pkg;

  localparam int unsigned ROB_LENGTH      = 16;
  localparam int unsigned ROB_IDX_W       = 4;
  localparam int unsigned ROB_CNT_W       = ROB_IDX_W + 1;
  localparam int unsigned INSTR_MEM_IDX_W = 16;
  localparam int unsigned ARCH_REG_IDX_W  = 5;
  localparam int unsigned PHYS_REG_IDX_W  = 6;

  // One ROB storage entry as seen on the head read port.
  typedef struct packed {
    logic                       valid;
    logic                       done;
    logic                       is_store;
    logic                       is_load;
    logic                       is_branch;
    logic                       pred_taken;
    logic [INSTR_MEM_IDX_W-1:0] pc;
    logic [INSTR_MEM_IDX_W-1:0] pred_target;
    logic [ARCH_REG_IDX_W-1:0]  logical_rd;
    logic [PHYS_REG_IDX_W-1:0]  phys_rd;
  } rob_entry_t;

  // Retirement bundle sent to the retirement RAT, free list and store buffer.
  typedef struct packed {
    logic [ARCH_REG_IDX_W-1:0] logical_rd;
    logic [PHYS_REG_IDX_W-1:0] phys_rd;
    logic                      rd_we;
    logic                      is_store;
    logic                      is_load;
  } rob_commit_t;

endpackage

// File: rtl/rob_commit_unit_resolve_table.sv
// Per-entry completion flags and resolved branch outcomes, read at the head.
module rob_resolve_table #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TGT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_clr,
  input  logic [IDX_W-1:0] i_clr_idx,
  input  logic             i_set,
  input  logic [IDX_W-1:0] i_set_idx,
  input  logic             i_set_branch,
  input  logic             i_act_taken,
  input  logic [TGT_W-1:0] i_act_target,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_done,
  output logic             o_act_taken,
  output logic [TGT_W-1:0] o_act_target
);

  logic [DEPTH-1:0] r_done;
  logic [DEPTH-1:0] r_act_taken;
  logic [TGT_W-1:0] r_act_target [DEPTH];

  // Clear a slot on allocation, mark it on completion; flush drops all done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done      <= '0;
      r_act_taken <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        r_act_target[k] <= '0;
      end
    end else if (i_flush) begin
      r_done <= '0;
    end else begin
      if (i_clr) begin
        r_done[i_clr_idx] <= 1'b0;
      end
      if (i_set) begin
        r_done[i_set_idx] <= 1'b1;
        if (i_set_branch) begin
          r_act_taken[i_set_idx]  <= i_act_taken;
          r_act_target[i_set_idx] <= i_act_target;
        end
      end
    end
  end

  assign o_done       = r_done[i_rd_idx];
  assign o_act_taken  = r_act_taken[i_rd_idx];
  assign o_act_target = r_act_target[i_rd_idx];

endmodule

// File: rtl/rob_commit_unit.sv
// ROB pointer/occupancy owner: grants allocation, tracks completion and
// retires the head in order, raising flush on a mispredicted branch commit.
module rob_commit_unit
  import rob_commit_unit_pkg::*;
#(
  parameter int unsigned ROB_LENGTH      = rob_commit_unit_pkg::ROB_LENGTH,
  parameter int unsigned ROB_IDX_W       = rob_commit_unit_pkg::ROB_IDX_W,
  parameter int unsigned INSTR_MEM_IDX_W = rob_commit_unit_pkg::INSTR_MEM_IDX_W,
  parameter int unsigned ARCH_REG_IDX_W  = rob_commit_unit_pkg::ARCH_REG_IDX_W,
  parameter int unsigned PHYS_REG_IDX_W  = rob_commit_unit_pkg::PHYS_REG_IDX_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_alloc_req,
  output logic                       o_alloc_ready,
  output logic [ROB_IDX_W-1:0]       o_alloc_idx,
  output logic                       o_rob_write,
  output logic [ROB_IDX_W-1:0]       o_rob_head,
  output logic [ROB_IDX_W-1:0]       o_rob_tail,
  input  logic                       i_exec_valid,
  input  logic [ROB_IDX_W-1:0]       i_exec_rob_idx,
  input  logic                       i_exec_is_branch,
  input  logic                       i_actual_taken,
  input  logic [INSTR_MEM_IDX_W-1:0] i_actual_target,
  input  logic                       i_head_valid,
  input  logic                       i_head_done,
  input  logic                       i_head_is_store,
  input  logic                       i_head_is_load,
  input  logic                       i_head_is_branch,
  input  logic                       i_head_pred_taken,
  input  logic [INSTR_MEM_IDX_W-1:0] i_head_pc,
  input  logic [INSTR_MEM_IDX_W-1:0] i_head_pred_target,
  input  logic [ARCH_REG_IDX_W-1:0]  i_head_logical_rd,
  input  logic [PHYS_REG_IDX_W-1:0]  i_head_phys_rd,
  input  logic                       i_store_ready,
  output logic                       o_commit_valid,
  output logic                       o_commit_rd_we,
  output logic [ARCH_REG_IDX_W-1:0]  o_commit_logical_rd,
  output logic [PHYS_REG_IDX_W-1:0]  o_commit_phys_rd,
  output logic                       o_commit_is_store,
  output logic                       o_commit_is_load,
  output logic                       o_flush,
  output logic [INSTR_MEM_IDX_W-1:0] o_redirect_pc
);

  localparam int unsigned CNT_W = ROB_IDX_W + 1;
  localparam logic [CNT_W-1:0]     LenCnt  = CNT_W'(ROB_LENGTH);
  localparam logic [ROB_IDX_W-1:0] LastIdx = ROB_IDX_W'(ROB_LENGTH - 1);

  logic [ROB_IDX_W-1:0]       r_head;
  logic [ROB_IDX_W-1:0]       r_tail;
  logic [CNT_W-1:0]           r_count;

  logic                       w_empty;
  logic                       w_full;
  logic                       w_done_rd;
  logic                       w_act_taken;
  logic [INSTR_MEM_IDX_W-1:0] w_act_target;
  logic                       w_entry_done;
  logic                       w_commit_valid;
  logic                       w_mispred;
  logic                       w_flush;
  logic                       w_alloc_ready;
  logic                       w_write;
  logic                       w_exec_set;
  rob_commit_t                w_commit;

  // Explicit wrap so non-power-of-two lengths work.
  function automatic logic [ROB_IDX_W-1:0] inc_idx(input logic [ROB_IDX_W-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + 1'b1;
  endfunction

  rob_resolve_table #(
    .DEPTH (ROB_LENGTH),
    .IDX_W (ROB_IDX_W),
    .TGT_W (INSTR_MEM_IDX_W)
  ) u_resolve (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (w_flush),
    .i_clr        (w_write),
    .i_clr_idx    (r_tail),
    .i_set        (w_exec_set),
    .i_set_idx    (i_exec_rob_idx),
    .i_set_branch (i_exec_is_branch),
    .i_act_taken  (i_actual_taken),
    .i_act_target (i_actual_target),
    .i_rd_idx     (r_head),
    .o_done       (w_done_rd),
    .o_act_taken  (w_act_taken),
    .o_act_target (w_act_target)
  );

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == LenCnt);
  assign w_entry_done = i_head_done || w_done_rd;

  // Head retirement, mispredict detection and allocation grant (all combinational).
  always_comb begin
    w_commit_valid = !rst && !w_empty && i_head_valid && w_entry_done &&
                     (!i_head_is_store || i_store_ready);
    w_mispred      = i_head_is_branch &&
                     ((w_act_taken != i_head_pred_taken) ||
                      (w_act_taken && (w_act_target != i_head_pred_target)));
    w_flush        = w_commit_valid && w_mispred;
    // Grant depends on occupancy before this cycle's commit.
    w_alloc_ready  = !rst && !w_full && !w_flush;
    w_write        = i_alloc_req && w_alloc_ready;
    w_exec_set     = i_exec_valid && !w_flush;

    w_commit            = '0;
    if (w_commit_valid) begin
      w_commit.logical_rd = i_head_logical_rd;
      w_commit.phys_rd    = i_head_phys_rd;
      w_commit.is_store   = i_head_is_store;
      w_commit.is_load    = i_head_is_load;
      w_commit.rd_we      = (i_head_logical_rd != '0) && !i_head_is_store && !i_head_is_branch;
    end

    o_redirect_pc = '0;
    if (w_flush) begin
      o_redirect_pc = w_act_taken ? w_act_target : i_head_pc + INSTR_MEM_IDX_W'(1);
    end
  end

  // Pointer and occupancy update; a flushing commit empties the whole buffer.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_tail <= inc_idx(r_tail);
      end
      if (w_commit_valid) begin
        r_head <= inc_idx(r_head);
      end
      r_count <= r_count + CNT_W'(w_write) - CNT_W'(w_commit_valid);
    end
  end

  assign o_alloc_ready       = w_alloc_ready;
  assign o_rob_write         = w_write;
  assign o_rob_head          = rst ? '0 : r_head;
  assign o_rob_tail          = rst ? '0 : r_tail;
  assign o_alloc_idx         = rst ? '0 : r_tail;
  assign o_commit_valid      = w_commit_valid;
  assign o_commit_rd_we      = w_commit.rd_we;
  assign o_commit_logical_rd = w_commit.logical_rd;
  assign o_commit_phys_rd    = w_commit.phys_rd;
  assign o_commit_is_store   = w_commit.is_store;
  assign o_commit_is_load    = w_commit.is_load;
  assign o_flush             = w_flush;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit with a behavioural ROB storage array.
module tb_rob_commit_unit;
  import rob_commit_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_req, exec_valid, exec_is_branch, actual_taken, store_ready;
  logic [3:0]  exec_idx;
  logic [15:0] actual_target;
  logic        alloc_ready, rob_write, commit_valid, commit_rd_we;
  logic        commit_is_store, commit_is_load, flush;
  logic [3:0]  alloc_idx, rob_head, rob_tail;
  logic [4:0]  commit_lrd;
  logic [5:0]  commit_prd;
  logic [15:0] redirect_pc;

  rob_entry_t mem [16];
  rob_entry_t alloc_entry;
  rob_entry_t head_e;
  logic       mem_clr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Storage array: written at the tail on rob_write, read asynchronously at head.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 16; k++) mem[k] <= '0;
    end else if (rob_write) begin
      mem[rob_tail] <= alloc_entry;
    end
  end
  assign head_e = mem[rob_head];

  rob_commit_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_alloc_req         (alloc_req),
    .o_alloc_ready       (alloc_ready),
    .o_alloc_idx         (alloc_idx),
    .o_rob_write         (rob_write),
    .o_rob_head          (rob_head),
    .o_rob_tail          (rob_tail),
    .i_exec_valid        (exec_valid),
    .i_exec_rob_idx      (exec_idx),
    .i_exec_is_branch    (exec_is_branch),
    .i_actual_taken      (actual_taken),
    .i_actual_target     (actual_target),
    .i_head_valid        (head_e.valid),
    .i_head_done         (head_e.done),
    .i_head_is_store     (head_e.is_store),
    .i_head_is_load      (head_e.is_load),
    .i_head_is_branch    (head_e.is_branch),
    .i_head_pred_taken   (head_e.pred_taken),
    .i_head_pc           (head_e.pc),
    .i_head_pred_target  (head_e.pred_target),
    .i_head_logical_rd   (head_e.logical_rd),
    .i_head_phys_rd      (head_e.phys_rd),
    .i_store_ready       (store_ready),
    .o_commit_valid      (commit_valid),
    .o_commit_rd_we      (commit_rd_we),
    .o_commit_logical_rd (commit_lrd),
    .o_commit_phys_rd    (commit_prd),
    .o_commit_is_store   (commit_is_store),
    .o_commit_is_load    (commit_is_load),
    .o_flush             (flush),
    .o_redirect_pc       (redirect_pc)
  );

  typedef struct {
    logic       alloc;
    logic       ex_v;
    logic [3:0] ex_idx;
    logic       e_ready;
    logic       e_cv;
    logic       e_we;
    logic [4:0] e_lrd;
    logic [5:0] e_prd;
    logic [3:0] e_head;
    logic [3:0] e_tail;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(input logic a, input logic ev, input logic [3:0] ei,
                              input logic rdy, input logic cv, input logic we,
                              input logic [4:0] lrd, input logic [5:0] prd,
                              input logic [3:0] hd, input logic [3:0] tl);
    vec_t v;
    v.alloc = a; v.ex_v = ev; v.ex_idx = ei; v.e_ready = rdy; v.e_cv = cv; v.e_we = we;
    v.e_lrd = lrd; v.e_prd = prd; v.e_head = hd; v.e_tail = tl;
    return v;
  endfunction

  // Plain ALU entry: idx 0 has rd=0, idx 1 is rd=5/p37, others rd=i+5/p(40+i).
  function automatic rob_entry_t ent(input int i);
    rob_entry_t e;
    e            = '0;
    e.valid      = 1'b1;
    e.pc         = 16'(i);
    e.logical_rd = (i == 0) ? 5'd0 : (i == 1) ? 5'd5 : 5'(i + 5);
    e.phys_rd    = (i == 1) ? 6'd37 : 6'(40 + i);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic a, input rob_entry_t e, input logic ev, input logic [3:0] ei,
                     input logic eb, input logic at, input logic [15:0] atg, input logic sr);
    @(negedge clk);
    alloc_req = a; alloc_entry = e; exec_valid = ev; exec_idx = ei;
    exec_is_branch = eb; actual_taken = at; actual_target = atg; store_ready = sr;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rob_entry_t st, br, ld;
    rst = 1'b1; mem_clr = 1'b1;
    alloc_req = 1'b1; exec_valid = 1'b0; exec_idx = '0; exec_is_branch = 1'b0;
    actual_taken = 1'b0; actual_target = '0; store_ready = 1'b1; alloc_entry = '0;

    // Fill, out-of-order completion, full-ROB rejection and simultaneous alloc/commit.
    for (int i = 0; i < 16; i++) vecs[i] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 4'(i));
    vecs[16] = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[18] = mk(1, 1, 1, 0, 1, 0, 0, 40, 0, 0);
    vecs[19] = mk(1, 0, 0, 1, 1, 1, 5, 37, 1, 0);
    vecs[20] = mk(1, 0, 0, 1, 1, 1, 7, 42, 2, 1);
    vecs[21] = mk(1, 0, 0, 1, 0, 0, 0, 0, 3, 2);
    vecs[22] = mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 3);

    repeat (2) @(negedge clk);
    #2;
    chk("rst_alloc_ready", alloc_ready, 0);
    chk("rst_rob_write", rob_write, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_head", rob_head, 0);
    chk("rst_tail", rob_tail, 0);
    chk("rst_flush", flush, 0);
    @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0; alloc_req = 1'b0;

    for (int i = 0; i < 23; i++) begin
      cyc(vecs[i].alloc, ent(i), vecs[i].ex_v, vecs[i].ex_idx, 0, 0, 0, 1);
      chk($sformatf("v%0d_alloc_ready", i), alloc_ready, vecs[i].e_ready);
      chk($sformatf("v%0d_rob_write", i), rob_write, vecs[i].alloc && vecs[i].e_ready);
      chk($sformatf("v%0d_alloc_idx", i), alloc_idx, vecs[i].e_tail);
      chk($sformatf("v%0d_tail", i), rob_tail, vecs[i].e_tail);
      chk($sformatf("v%0d_head", i), rob_head, vecs[i].e_head);
      chk($sformatf("v%0d_commit_valid", i), commit_valid, vecs[i].e_cv);
      chk($sformatf("v%0d_rd_we", i), commit_rd_we, vecs[i].e_we);
      chk($sformatf("v%0d_lrd", i), commit_lrd, vecs[i].e_lrd);
      chk($sformatf("v%0d_prd", i), commit_prd, vecs[i].e_prd);
      chk($sformatf("v%0d_flush", i), flush, 0);
    end

    // Reset mid-operation discards the full ROB without committing.
    @(negedge clk);
    rst = 1'b1; alloc_req = 1'b1; #2;
    chk("midrst_alloc_ready", alloc_ready, 0);
    chk("midrst_rob_write", rob_write, 0);
    chk("midrst_head", rob_head, 0);
    chk("midrst_commit_valid", commit_valid, 0);
    @(negedge clk);
    rst = 1'b0; alloc_req = 1'b0; #2;
    chk("postrst_alloc_ready", alloc_ready, 1);
    chk("postrst_tail", rob_tail, 0);
    chk("postrst_commit_valid", commit_valid, 0);

    // Store allocated done; stalls on store_ready for three cycles.
    st = '0; st.valid = 1; st.done = 1; st.is_store = 1; st.logical_rd = 9; st.phys_rd = 50;
    cyc(1, st, 0, 0, 0, 0, 0, 0);
    chk("st_alloc_idx", alloc_idx, 0);
    chk("st_write", rob_write, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, st, 0, 0, 0, 0, 0, 0);
      chk($sformatf("st_wait%0d_commit_valid", k), commit_valid, 0);
    end
    cyc(0, st, 0, 0, 0, 0, 0, 1);
    chk("st_commit_valid", commit_valid, 1);
    chk("st_commit_is_store", commit_is_store, 1);
    chk("st_rd_we", commit_rd_we, 0);
    chk("st_lrd", commit_lrd, 9);
    cyc(0, st, 0, 0, 0, 0, 0, 1);
    chk("st_after_commit_valid", commit_valid, 0);
    chk("st_after_head", rob_head, 1);

    // Branch predicted not-taken, resolves taken to 0x40.
    br = '0; br.valid = 1; br.is_branch = 1; br.pc = 16'h30; br.logical_rd = 3;
    cyc(1, br, 0, 0, 0, 0, 0, 1);
    chk("br1_alloc_idx", alloc_idx, 1);
    cyc(1, ent(5), 1, 1, 1, 1, 16'h40, 1);
    chk("br1_no_bypass", commit_valid, 0);
    chk("br1_alloc_idx2", alloc_idx, 2);
    cyc(1, ent(6), 1, 2, 0, 0, 0, 1);
    chk("br1_commit_valid", commit_valid, 1);
    chk("br1_flush", flush, 1);
    chk("br1_redirect", redirect_pc, 16'h40);
    chk("br1_alloc_ready", alloc_ready, 0);
    chk("br1_rob_write", rob_write, 0);
    chk("br1_rd_we", commit_rd_we, 0);
    cyc(0, ent(6), 0, 0, 0, 0, 0, 1);
    chk("br1_post_head", rob_head, 0);
    chk("br1_post_tail", rob_tail, 0);
    chk("br1_post_alloc_ready", alloc_ready, 1);
    chk("br1_post_commit_valid", commit_valid, 0);
    chk("br1_post_flush", flush, 0);

    // Predicted taken to 0x20, resolves not-taken: redirect to pc+1.
    br = '0; br.valid = 1; br.is_branch = 1; br.pc = 16'h10; br.pred_taken = 1;
    br.pred_target = 16'h20;
    cyc(1, br, 0, 0, 0, 0, 0, 1);
    cyc(0, br, 1, 0, 1, 0, 0, 1);
    chk("br2_wait", commit_valid, 0);
    cyc(0, br, 0, 0, 0, 0, 0, 1);
    chk("br2_commit_valid", commit_valid, 1);
    chk("br2_flush", flush, 1);
    chk("br2_redirect", redirect_pc, 16'h11);
    cyc(0, br, 0, 0, 0, 0, 0, 1);
    chk("br2_post_tail", rob_tail, 0);
    chk("br2_post_commit_valid", commit_valid, 0);

    // Correctly predicted taken branch retires without flush.
    br.pc = 16'h5;
    cyc(1, br, 0, 0, 0, 0, 0, 1);
    cyc(0, br, 1, 0, 1, 1, 16'h20, 1);
    cyc(0, br, 0, 0, 0, 0, 0, 1);
    chk("br3_commit_valid", commit_valid, 1);
    chk("br3_flush", flush, 0);
    chk("br3_redirect", redirect_pc, 0);

    // Load allocated already done commits on the very next cycle.
    ld = '0; ld.valid = 1; ld.done = 1; ld.is_load = 1; ld.logical_rd = 4; ld.phys_rd = 44;
    cyc(1, ld, 0, 0, 0, 0, 0, 1);
    chk("ld_alloc_idx", alloc_idx, 1);
    cyc(0, ld, 0, 0, 0, 0, 0, 1);
    chk("ld_commit_valid", commit_valid, 1);
    chk("ld_is_load", commit_is_load, 1);
    chk("ld_rd_we", commit_rd_we, 1);
    chk("ld_prd", commit_prd, 44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
